// File: rtl/multiport_regfile.sv
// Multi-port register file: NUM_WR writes / NUM_RD reads per cycle, priority collision flag, optional bypass, bulk clear.
// Reads return one cycle after rd_en; no backpressure, but writes are dropped while the clear engine holds busy.
module multiport_regfile #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 4,
    parameter int BYPASS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]  wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_conflict,
    input  logic                     clear_req,
    output logic                     busy
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_clr_idx;
    logic                      r_busy;
    logic                      r_wr_conflict;
    logic [NUM_RD*WIDTH-1:0]   r_rd_data;
    logic [NUM_RD-1:0]         r_rd_valid;
    logic [WIDTH-1:0]          r_mem [DEPTH];

    logic [NUM_WR-1:0]         w_wr_ok;
    logic [DEPTH-1:0]          w_wr_hit;
    logic [WIDTH-1:0]          w_wr_dat [DEPTH];
    logic                      w_conflict;
    logic [WIDTH-1:0]          w_rd_val [NUM_RD];

    // Out-of-range or busy-cycle writes are removed before collision detection.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_ok[p] = wr_en[p] && !r_busy &&
                         ({1'b0, wr_addr[p*ADDR_W +: ADDR_W]} < DEPTH_LIM);
        end
    end

    // Ascending port scan: the first hit wins, any later hit on that entry is a collision.
    always_comb begin
        w_wr_hit   = '0;
        w_conflict = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wr_dat[e] = '0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
                    if (!w_wr_hit[e]) begin
                        w_wr_hit[e] = 1'b1;
                        w_wr_dat[e] = wr_data[p*WIDTH +: WIDTH];
                    end else begin
                        w_conflict = 1'b1;
                    end
                end
            end
        end
    end

    // An address that matches no entry reads as zero; hits are empty while busy, so no bypass then.
    always_comb begin
        for (int q = 0; q < NUM_RD; q++) begin
            w_rd_val[q] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (rd_addr[q*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
                    w_rd_val[q] = ((BYPASS != 0) && w_wr_hit[e]) ? w_wr_dat[e] : r_mem[e];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_clr_idx     <= '0;
            r_busy        <= 1'b0;
            r_wr_conflict <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            r_wr_conflict <= w_conflict;
            r_rd_valid    <= rd_en;
            for (int q = 0; q < NUM_RD; q++) begin
                if (rd_en[q]) begin
                    r_rd_data[q*WIDTH +: WIDTH] <= w_rd_val[q];
                end
            end
            for (int e = 0; e < DEPTH; e++) begin
                if (r_busy && (r_clr_idx == ADDR_W'(e))) begin
                    r_mem[e] <= '0;
                end else if (w_wr_hit[e]) begin
                    r_mem[e] <= w_wr_dat[e];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_state   <= S_IDLE;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign wr_conflict = r_wr_conflict;
    assign busy        = r_busy;

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: default build (DEPTH=8, bypass) and a DEPTH=6, no-bypass build share one stimulus stream.
module tb_multiport_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_en;
    logic [11:0] rd_addr;
    logic        clear_req;

    logic [31:0] rd_data,  b_rd_data;
    logic [3:0]  rd_valid, b_rd_valid;
    logic        wr_conflict, b_wr_conflict;
    logic        busy, b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multiport_regfile #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .NUM_WR(4), .NUM_RD(4), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_conflict(wr_conflict), .clear_req(clear_req), .busy(busy)
    );

    multiport_regfile #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .NUM_WR(4), .NUM_RD(4), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .wr_conflict(b_wr_conflict), .clear_req(clear_req), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in;
        wr_en     = '0;
        rd_en     = '0;
        clear_req = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [2:0] a, input logic [7:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*3 +: 3]   = a;
        wr_data[p*8 +: 8]   = d;
    endtask

    task automatic read4(input logic [2:0] a0, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] a3);
        rd_en   = 4'hF;
        rd_addr = {a3, a2, a1, a0};
        tick();
        rd_en   = '0;
    endtask

    initial begin
        int cnt;
        int bcnt;
        int n;

        reset   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        idle_in();
        tick();
        tick();
        chk("rst_rd_valid", {28'd0, rd_valid}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_conflict", {31'd0, wr_conflict}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b1;

        // T1: fill with AA, then reset wipes everything
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 4; p++) set_wr(p, 3'(i*4 + p), 8'hAA);
            tick();
            idle_in();
        end
        read4(3'd4, 3'd5, 3'd6, 3'd7);
        chk("t1_prefill", rd_data, 32'hAAAAAAAA);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t1_rst_valid", {28'd0, rd_valid}, 32'h0);
        chk("t1_rst_data", rd_data, 32'h0);
        chk("t1_rst_busy", {30'd0, busy, b_busy}, 32'h0);
        read4(3'd0, 3'd1, 3'd2, 3'd3);
        chk("t1_lo_zero", rd_data, 32'h0);
        read4(3'd4, 3'd5, 3'd6, 3'd7);
        chk("t1_hi_zero", rd_data, 32'h0);

        // T2: four parallel writes, then four parallel reads
        set_wr(0, 3'd0, 8'h11);
        set_wr(1, 3'd1, 8'h22);
        set_wr(2, 3'd2, 8'h33);
        set_wr(3, 3'd3, 8'h44);
        tick();
        idle_in();
        chk("t2_no_conflict", {31'd0, wr_conflict}, 32'h0);
        read4(3'd0, 3'd1, 3'd2, 3'd3);
        chk("t2_rd_data", rd_data, 32'h44332211);
        chk("t2_rd_valid", {28'd0, rd_valid}, 32'hF);
        chk("t2_b_rd_data", b_rd_data, 32'h44332211);
        tick();
        chk("t2_valid_drop", {28'd0, rd_valid}, 32'h0);
        chk("t2_data_hold", rd_data, 32'h44332211);

        // T3: ports 1 and 3 collide on addr 5; port 1 wins
        set_wr(1, 3'd5, 8'h55);
        set_wr(3, 3'd5, 8'h77);
        tick();
        idle_in();
        chk("t3_conflict", {31'd0, wr_conflict}, 32'h1);
        chk("t3_b_conflict", {31'd0, b_wr_conflict}, 32'h1);
        tick();
        chk("t3_conflict_pulse", {31'd0, wr_conflict}, 32'h0);
        read4(3'd5, 3'd5, 3'd5, 3'd5);
        chk("t3_winner", rd_data, 32'h55555555);
        // addr 7 collision: real in DEPTH=8, out of range (no conflict) in DEPTH=6
        set_wr(0, 3'd7, 8'h01);
        set_wr(1, 3'd7, 8'h02);
        tick();
        idle_in();
        chk("t3_conflict_a7", {31'd0, wr_conflict}, 32'h1);
        chk("t3_b_oor_noconf", {31'd0, b_wr_conflict}, 32'h0);
        read4(3'd7, 3'd7, 3'd7, 3'd7);
        chk("t3_a7_winner", rd_data, 32'h01010101);
        chk("t3_b_oor_rd", b_rd_data, 32'h0);
        chk("t3_b_oor_valid", {28'd0, b_rd_valid}, 32'hF);

        // T4: same-cycle write and read of addr 2
        set_wr(0, 3'd2, 8'h3C);
        rd_en          = 4'b0001;
        rd_addr[2:0]   = 3'd2;
        tick();
        idle_in();
        chk("t4_bypass", {24'd0, rd_data[7:0]}, 32'h3C);
        chk("t4_b_old", {24'd0, b_rd_data[7:0]}, 32'h33);
        chk("t4_valid", {28'd0, rd_valid}, 32'h1);
        set_wr(2, 3'd4, 8'h12);
        set_wr(3, 3'd4, 8'h34);
        rd_en          = 4'b0001;
        rd_addr[2:0]   = 3'd4;
        tick();
        idle_in();
        chk("t4_bypass_win", {24'd0, rd_data[7:0]}, 32'h12);
        chk("t4_b_old_a4", {24'd0, b_rd_data[7:0]}, 32'h0);
        read4(3'd2, 3'd2, 3'd4, 3'd4);
        chk("t4_committed", rd_data, 32'h12123C3C);

        // T5: bulk clear with writes hammering the ports while busy
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt  = 0;
        bcnt = 0;
        n    = 0;
        while (busy && n < 20) begin
            cnt++;
            if (b_busy) bcnt++;
            set_wr(0, 3'd0, 8'hFF);
            set_wr(1, 3'd0, 8'hFE);
            set_wr(2, 3'd1, 8'hFD);
            set_wr(3, 3'd7, 8'hFC);
            tick();
            chk("t5_no_conflict", {31'd0, wr_conflict}, 32'h0);
            n++;
        end
        idle_in();
        chk("t5_busy_cycles", cnt, 32'd8);
        chk("t5_b_busy_cycles", bcnt, 32'd6);
        read4(3'd0, 3'd1, 3'd2, 3'd3);
        chk("t5_lo_zero", rd_data, 32'h0);
        read4(3'd4, 3'd5, 3'd6, 3'd7);
        chk("t5_hi_zero", rd_data, 32'h0);

        // T6: reset during the third clear cycle
        set_wr(0, 3'd4, 8'h01);
        set_wr(1, 3'd5, 8'h02);
        set_wr(2, 3'd6, 8'h03);
        set_wr(3, 3'd7, 8'h04);
        tick();
        idle_in();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        chk("t6_busy_mid", {31'd0, busy}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_abort_busy", {31'd0, busy}, 32'h0);
        tick();
        chk("t6_stays_idle", {30'd0, busy, b_busy}, 32'h0);
        read4(3'd4, 3'd5, 3'd6, 3'd7);
        chk("t6_hi_zero", rd_data, 32'h0);

        // out-of-range writes on the DEPTH=6 build are dropped and read as zero
        set_wr(0, 3'd7, 8'h99);
        set_wr(1, 3'd6, 8'h98);
        set_wr(2, 3'd5, 8'h97);
        tick();
        idle_in();
        read4(3'd7, 3'd6, 3'd5, 3'd5);
        chk("t6_in_range", rd_data, 32'h97979899);
        chk("t6_b_oor", b_rd_data, 32'h97970000);
        chk("t6_b_valid", {28'd0, b_rd_valid}, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
